// File: rtl/mmc_arbiter.sv
// Round-robin scheduler sharing one iterative LCM engine among N requesters.
// Captures operands at grant, masks the engine's stale done after load, rejects zero operands, bounds run time.
module mmc_arbiter #(
  parameter int  N          = 4,
  parameter int  W          = 32,
  parameter int  SETTLE_CYC = 3,
  parameter int  TIMEOUT    = 65535,
  localparam int IW         = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] op_a,
  input  logic [N*W-1:0] op_b,
  output logic [N-1:0]   gnt,
  output logic           busy,
  output logic           rsp_valid,
  output logic [IW-1:0]  rsp_id,
  output logic [W-1:0]   rsp_res,
  output logic [1:0]     rsp_err,
  output logic           eng_ld,
  output logic [W-1:0]   eng_a,
  output logic [W-1:0]   eng_b,
  input  logic [W-1:0]   eng_res,
  input  logic           eng_done
);

  localparam int SCW = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
  localparam int RCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ZERO    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  state_t         state_r, state_s;
  logic [IW-1:0]  ptr_r, ptr_s;
  logic [IW-1:0]  sel_r, sel_s;
  logic [W-1:0]   a_r, a_s;
  logic [W-1:0]   b_r, b_s;
  logic [SCW-1:0] scnt_r, scnt_s;
  logic [RCW-1:0] rcnt_r, rcnt_s;
  logic [W-1:0]   res_r, res_s;
  logic [1:0]     err_r, err_s;
  logic [IW-1:0]  pick_s;
  logic [W-1:0]   cand_a_s;
  logic [W-1:0]   cand_b_s;
  logic [N-1:0]   gnt_s;

  // First set request after ptr, wrapping; the nearest candidate is evaluated last so it wins.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] p);
    logic [IW-1:0] pick;
    int            idx;
    pick = p;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(p) + k) % N;
      if (r[idx]) begin
        pick = IW'(idx);
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  function automatic logic [N-1:0] to_onehot(input logic [IW-1:0] i);
    logic [N-1:0] v;
    v    = {N{1'b0}};
    v[i] = 1'b1;
    return v;
  endfunction

  // Next-state and transaction datapath decode.
  always_comb begin
    state_s  = state_r;
    ptr_s    = ptr_r;
    sel_s    = sel_r;
    a_s      = a_r;
    b_s      = b_r;
    scnt_s   = scnt_r;
    rcnt_s   = rcnt_r;
    res_s    = res_r;
    err_s    = err_r;
    gnt_s    = {N{1'b0}};
    pick_s   = rr_pick(req, ptr_r);
    cand_a_s = op_a[int'(pick_s)*W +: W];
    cand_b_s = op_b[int'(pick_s)*W +: W];
    case (state_r)
      ST_IDLE: begin
        if (|req) begin
          gnt_s = to_onehot(pick_s);
          ptr_s = pick_s;
          sel_s = pick_s;
          a_s   = cand_a_s;
          b_s   = cand_b_s;
          // A zero operand would never converge, so the engine is bypassed entirely.
          if ((cand_a_s == {W{1'b0}}) || (cand_b_s == {W{1'b0}})) begin
            res_s   = {W{1'b0}};
            err_s   = ERR_ZERO;
            state_s = ST_RESP;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        scnt_s  = SCW'(SETTLE_CYC - 1);
        state_s = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (scnt_r == {SCW{1'b0}}) begin
          rcnt_s  = {RCW{1'b0}};
          state_s = ST_RUN;
        end else begin
          scnt_s  = scnt_r - SCW'(1);
          state_s = ST_SETTLE;
        end
      end
      ST_RUN: begin
        if (eng_done) begin
          res_s   = eng_res;
          err_s   = ERR_OK;
          state_s = ST_RESP;
        end else if (rcnt_r == RCW'(TIMEOUT - 1)) begin
          res_s   = {W{1'b0}};
          err_s   = ERR_TIMEOUT;
          state_s = ST_RESP;
        end else begin
          rcnt_s  = rcnt_r + RCW'(1);
          state_s = ST_RUN;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Control state and captured transaction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ptr_r   <= IW'(N - 1);
      sel_r   <= {IW{1'b0}};
      a_r     <= {W{1'b0}};
      b_r     <= {W{1'b0}};
      scnt_r  <= {SCW{1'b0}};
      rcnt_r  <= {RCW{1'b0}};
      res_r   <= {W{1'b0}};
      err_r   <= 2'b00;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      sel_r   <= sel_s;
      a_r     <= a_s;
      b_r     <= b_s;
      scnt_r  <= scnt_s;
      rcnt_r  <= rcnt_s;
      res_r   <= res_s;
      err_r   <= err_s;
    end
  end

  // Output registers: engine and response strobes trail the state that issues them by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt       <= {N{1'b0}};
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= {IW{1'b0}};
      rsp_res   <= {W{1'b0}};
      rsp_err   <= 2'b00;
      eng_ld    <= 1'b0;
      eng_a     <= {W{1'b0}};
      eng_b     <= {W{1'b0}};
    end else begin
      gnt       <= gnt_s;
      busy      <= (state_s != ST_IDLE);
      rsp_valid <= (state_r == ST_RESP);
      eng_ld    <= (state_r == ST_LOAD);
      if (state_r == ST_LOAD) begin
        eng_a <= a_r;
        eng_b <= b_r;
      end else begin
        eng_a <= eng_a;
        eng_b <= eng_b;
      end
      if (state_r == ST_RESP) begin
        rsp_id  <= sel_r;
        rsp_res <= res_r;
        rsp_err <= err_r;
      end else begin
        rsp_id  <= rsp_id;
        rsp_res <= rsp_res;
        rsp_err <= rsp_err;
      end
    end
  end

endmodule

// File: tb/tb_mmc_arbiter.sv
// Scoreboard bench for mmc_arbiter with a slow iterative LCM engine model whose done flag survives a load.
module tb_mmc_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SC = 3;
  localparam int TO = 16;
  localparam int IW = 2;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [W-1:0]  res;
    logic [1:0]    err;
  } rsp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] op_a, op_b;
  logic [N-1:0]   gnt;
  logic           busy, rsp_valid, eng_ld, eng_done;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_res, eng_a, eng_b, eng_res;
  logic [1:0]     rsp_err;

  int             n_checks = 0;
  int             n_pass   = 0;
  rsp_t           exp_q[$];
  rsp_t           mon_e;
  logic [W-1:0]   ta[N];
  logic [W-1:0]   tb_op[N];
  int             exp_ptr;
  logic           eng_hold;

  // Engine model: load is staged one extra cycle, done is only recomputed after that.
  logic [W-1:0]   stg_a_r = '0, stg_b_r = '0, ea_r = '0, eb_r = '0, m1_r = '0, m2_r = '0;
  logic           pend_r = 1'b0, done_r = 1'b0;

  always #5 clk = ~clk;

  mmc_arbiter #(.N(N), .W(W), .SETTLE_CYC(SC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_err(rsp_err), .eng_ld(eng_ld), .eng_a(eng_a),
    .eng_b(eng_b), .eng_res(eng_res), .eng_done(eng_done)
  );

  always @(posedge clk) begin
    if (eng_ld) begin
      stg_a_r <= eng_a;
      stg_b_r <= eng_b;
      pend_r  <= 1'b1;
    end else if (pend_r) begin
      ea_r   <= stg_a_r;
      eb_r   <= stg_b_r;
      m1_r   <= stg_a_r;
      m2_r   <= stg_b_r;
      pend_r <= 1'b0;
    end else if (m1_r == m2_r) begin
      done_r <= 1'b1;
    end else begin
      done_r <= 1'b0;
      if (m1_r < m2_r) m1_r <= m1_r + ea_r;
      else             m2_r <= m2_r + eb_r;
    end
  end

  assign eng_done = done_r & ~eng_hold;
  assign eng_res  = m1_r;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] lcm(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != '0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return (a / x) * b;
  endfunction

  function automatic int rr_next(input logic [N-1:0] m, input int p);
    for (int k = 1; k <= N; k++) begin
      if (m[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  // Response monitor: every strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_id", rsp_id, mon_e.id);
        check("rsp_res", rsp_res, mon_e.res);
        check("rsp_err", rsp_err, mon_e.err);
      end
    end
  end

  task automatic chk_reset(input string p);
    check({p, "_gnt"}, gnt, 0);
    check({p, "_busy"}, busy, 0);
    check({p, "_rsp_valid"}, rsp_valid, 0);
    check({p, "_rsp_id"}, rsp_id, 0);
    check({p, "_rsp_res"}, rsp_res, 0);
    check({p, "_rsp_err"}, rsp_err, 0);
    check({p, "_eng_ld"}, eng_ld, 0);
    check({p, "_eng_a"}, eng_a, 0);
    check({p, "_eng_b"}, eng_b, 0);
  endtask

  task automatic wait_gnt(output logic [N-1:0] g);
    int cyc = 0;
    g = '0;
    while (g == '0 && cyc < 200) begin
      @(negedge clk);
      g = gnt;
      cyc++;
    end
    if (g == '0) check("gnt_wait_expired", 0, 1);
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic run_batch(input logic [N-1:0] mask);
    logic [N-1:0] pend, g, exp_g;
    int           e;
    rsp_t         x;
    for (int i = 0; i < N; i++) begin
      op_a[i*W +: W] = ta[i];
      op_b[i*W +: W] = tb_op[i];
    end
    pend = mask;
    req  = mask;
    while (pend != '0) begin
      wait_gnt(g);
      if (g == '0) return;
      e        = rr_next(pend, exp_ptr);
      exp_g    = '0;
      exp_g[e] = 1'b1;
      check("gnt_order", g, exp_g);
      exp_ptr = e;
      pend[e] = 1'b0;
      req     = pend;
      x.id    = IW'(e);
      x.err   = (ta[e] == '0 || tb_op[e] == '0) ? 2'b01 : 2'b00;
      x.res   = (x.err == 2'b01) ? '0 : lcm(ta[e], tb_op[e]);
      exp_q.push_back(x);
      op_a[e*W +: W] = ta[e] ^ 32'h5a5a_0001;
      @(negedge clk);
      check("gnt_pulse", gnt, 0);
      if (x.err == 2'b01) begin
        check("zero_no_ld", eng_ld, 0);
        check("zero_rsp_next", rsp_valid, 1);
      end else begin
        check("eng_ld", eng_ld, 1);
        check("eng_a", eng_a, ta[e]);
        check("eng_b", eng_b, tb_op[e]);
        @(negedge clk);
        check("eng_ld_pulse", eng_ld, 0);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [N-1:0] g;
    int           lat, cnt;
    rst = 1'b1; req = '0; op_a = '0; op_b = '0; eng_hold = 1'b0; exp_ptr = N - 1;
    for (int i = 0; i < N; i++) begin
      ta[i] = '0;
      tb_op[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst = 1'b0;
    @(negedge clk);

    ta[0] = 4; tb_op[0] = 6;
    run_batch(4'b0001); wait_idle();

    ta[0] = 3; tb_op[0] = 5; ta[1] = 7; tb_op[1] = 7; ta[3] = 9; tb_op[3] = 12;
    run_batch(4'b1011); wait_idle();

    ta[2] = 0; tb_op[2] = 5;
    run_batch(4'b0100); wait_idle();

    ta[1] = 10; tb_op[1] = 4; ta[2] = 6; tb_op[2] = 0;
    run_batch(4'b0110); wait_idle();

    // Engine still shows done from the previous result when this load happens.
    ta[0] = 8; tb_op[0] = 12;
    run_batch(4'b0001); wait_idle();

    eng_hold = 1'b1;
    op_a[0 +: W] = 5; op_b[0 +: W] = 7; req = 4'b0001;
    wait_gnt(g);
    check("to_gnt", g, 4'b0001);
    exp_ptr = 0; req = '0;
    exp_q.push_back('{id: 2'd0, res: '0, err: 2'b10});
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 10) check("to_busy", busy, 1);
    end
    check("to_latency", lat, 1 + SC + TO + 1);
    eng_hold = 1'b0;
    wait_idle();

    ta[1] = 6; tb_op[1] = 10;
    run_batch(4'b0010); wait_idle();

    eng_hold = 1'b1;
    op_a[0 +: W] = 9; op_b[0 +: W] = 6; req = 4'b0001;
    wait_gnt(g);
    check("rst_run_gnt", g, 4'b0001);
    req = '0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset("mid_rst");
    exp_ptr = N - 1;
    @(negedge clk);
    rst = 1'b0; eng_hold = 1'b0;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) cnt++;
    end
    check("no_rsp_after_rst", cnt, 0);

    ta[0] = 2; tb_op[0] = 3; ta[1] = 4; tb_op[1] = 5;
    ta[2] = 6; tb_op[2] = 4; ta[3] = 5; tb_op[3] = 5;
    run_batch(4'b1111); wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
